// File: rtl/inst_loader_if.sv
// Bundles the loader's host byte link, instruction-memory write port and pipeline controls.
// The loader uses the slave modport; the host/bench side uses master.
`timescale 1ns/1ps
interface inst_loader_if #(
  parameter int unsigned NB_DATA   = 32,
  parameter int unsigned NB_BYTE   = 8,
  parameter int unsigned NB_ADDR   = 32,
  parameter int unsigned MAX_WORDS = 64
);
  localparam int unsigned CW = $clog2(MAX_WORDS + 1);

  logic               i_start;
  logic               i_byte_valid;
  logic [NB_BYTE-1:0] i_byte;
  logic               o_byte_ready;
  logic               o_we_IF;
  logic [NB_ADDR-1:0] o_inst_addr;
  logic [NB_DATA-1:0] o_instruction_data;
  logic               o_cpu_rst_n;
  logic               o_halt;
  logic               o_done;
  logic               o_error;
  logic [CW-1:0]      o_word_count;

  modport slave (
    input  i_start, i_byte_valid, i_byte,
    output o_byte_ready, o_we_IF, o_inst_addr, o_instruction_data,
    output o_cpu_rst_n, o_halt, o_done, o_error, o_word_count
  );

  modport master (
    output i_start, i_byte_valid, i_byte,
    input  o_byte_ready, o_we_IF, o_inst_addr, o_instruction_data,
    input  o_cpu_rst_n, o_halt, o_done, o_error, o_word_count
  );
endinterface

// File: rtl/inst_loader.sv
// Program loader: packs link bytes into words, writes them until HALT, then pulses pipeline reset.
// Optional trailing checksum byte is enabled by defining LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module inst_loader #(
  parameter int unsigned        NB_DATA    = 32,
  parameter int unsigned        NB_BYTE    = 8,
  parameter int unsigned        NB_ADDR    = 32,
  parameter logic [NB_ADDR-1:0] START_ADDR = '0,
  parameter int unsigned        ADDR_STEP  = 4,
  parameter int unsigned        MAX_WORDS  = 64,
  parameter logic [NB_DATA-1:0] HALT_WORD  = '1,
  parameter int unsigned        RST_CYCLES = 2
) (
  input logic          clk,
  input logic          i_rst_n,
  inst_loader_if.slave bus
);

  localparam int unsigned BPW = NB_DATA / NB_BYTE;
  localparam int unsigned IW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned CW  = $clog2(MAX_WORDS + 1);
  localparam int unsigned RW  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWrite,
`ifdef LOADER_CHECKSUM_EN
    StCheck,
`endif
    StRstp,
    StRun,
    StError
  } state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [RW-1:0]      rst_cnt_q, rst_cnt_d;
`ifdef LOADER_CHECKSUM_EN
  logic [NB_BYTE-1:0] sum_q, sum_d;
`endif

  logic byte_ready_q, we_q, cpu_rst_n_q, halt_q, done_q, error_q;
  logic accept;

  assign accept = bus.i_byte_valid & byte_ready_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    addr_d    = addr_q;
    count_d   = count_q;
    rst_cnt_d = rst_cnt_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    unique case (state_q)
      StIdle, StRun, StError: begin
        if (bus.i_start) begin
          state_d = StLoad;
          addr_d  = START_ADDR;
          count_d = '0;
          idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      StLoad: begin
        if (accept) begin
          // Shifting left leaves the first byte of the word in the top lane.
          data_d = (data_q << NB_BYTE) | NB_DATA'(bus.i_byte);
`ifdef LOADER_CHECKSUM_EN
          sum_d  = sum_q + bus.i_byte;
`endif
          if (idx_q == IW'(BPW - 1)) begin
            idx_d   = '0;
            state_d = (count_q == CW'(MAX_WORDS)) ? StError : StWrite;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StWrite: begin
        addr_d  = addr_q + NB_ADDR'(ADDR_STEP);
        count_d = count_q + 1'b1;
        if (data_q == HALT_WORD) begin
          rst_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
          state_d   = StCheck;
`else
          state_d   = StRstp;
`endif
        end else begin
          state_d = StLoad;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck: begin
        if (accept) begin
          rst_cnt_d = '0;
          state_d   = (bus.i_byte == sum_q) ? StRstp : StError;
        end
      end
`endif
      StRstp: begin
        if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
          state_d = StRun;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      data_q       <= '0;
      addr_q       <= START_ADDR;
      count_q      <= '0;
      rst_cnt_q    <= '0;
      byte_ready_q <= 1'b0;
      we_q         <= 1'b0;
      cpu_rst_n_q  <= 1'b0;
      halt_q       <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      rst_cnt_q    <= rst_cnt_d;
      // Outputs are decoded from the next state so they are flops aligned with the state.
`ifdef LOADER_CHECKSUM_EN
      byte_ready_q <= (state_d == StLoad) || (state_d == StCheck);
`else
      byte_ready_q <= (state_d == StLoad);
`endif
      we_q         <= (state_d == StWrite);
      cpu_rst_n_q  <= (state_d == StRun);
      halt_q       <= (state_d != StRun);
      done_q       <= (state_d == StRun);
      error_q      <= (state_d == StError);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end
`endif

  assign bus.o_byte_ready       = byte_ready_q;
  assign bus.o_we_IF            = we_q;
  assign bus.o_inst_addr        = addr_q;
  assign bus.o_instruction_data = data_q;
  assign bus.o_cpu_rst_n        = cpu_rst_n_q;
  assign bus.o_halt             = halt_q;
  assign bus.o_done             = done_q;
  assign bus.o_error            = error_q;
  assign bus.o_word_count       = count_q;

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: a program-level model queues expected writes, a monitor checks.
`timescale 1ns/1ps
module tb_inst_loader;
  localparam int unsigned MAXW = 4;
  localparam int unsigned RSTC = 2;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;
  int   last_we;
  logic prev_we;
  logic prev_done;
  wr_t  exp_q[$];

  inst_loader_if #(.MAX_WORDS(MAXW)) bus ();

  inst_loader #(
    .MAX_WORDS (MAXW),
    .RST_CYCLES(RSTC)
  ) dut (
    .clk    (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every write pulse.
  initial begin : monitor
    wr_t e;
    cyc = 0;
    last_we = 0;
    prev_we = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.o_we_IF === 1'b1) begin
        chk("we_single_cycle", {63'd0, prev_we}, 64'd0);
        chk("ready_low_in_write", {63'd0, bus.o_byte_ready}, 64'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0h data %0h, no write expected",
                   bus.o_inst_addr, bus.o_instruction_data);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", {32'd0, bus.o_inst_addr}, {32'd0, e.addr});
          chk("write_data", {32'd0, bus.o_instruction_data}, {32'd0, e.data});
        end
        last_we = cyc;
      end
`ifndef LOADER_CHECKSUM_EN
      if (bus.o_done === 1'b1 && prev_done === 1'b0)
        chk("halt_to_done_cycles", 64'(cyc - last_we), 64'(RSTC + 1));
`endif
      prev_we = bus.o_we_IF;
      prev_done = bus.o_done;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int  n;
    logic r;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    bus.i_byte_valid = 1'b1;
    bus.i_byte = b;
    n = 0;
    forever begin
      @(negedge clk);
      r = bus.o_byte_ready;
      @(posedge clk);
      n++;
      if (r === 1'b1) break;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL byte_accept_timeout: byte %0h not accepted, acceptance required", b);
        break;
      end
    end
    #1;
    bus.i_byte_valid = 1'b0;
  endtask

  task automatic start_session();
    @(posedge clk);
    #1 bus.i_start = 1'b1;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
  endtask

  // Expected behaviour derived from the program contents alone.
  task automatic run_session(input logic [31:0] words[$], input int gap, input bit csum_ok);
    int          nsend;
    int          nwr;
    bit          exp_done;
    bit          halted;
    logic [7:0]  sum;
    logic [31:0] w;
    int          n;
    nsend = 0;
    nwr = 0;
    exp_done = 1'b0;
    halted = 1'b0;
    sum = 8'd0;
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      nsend++;
      sum = sum + w[31:24] + w[23:16] + w[15:8] + w[7:0];
      if (i == MAXW) break;
      exp_q.push_back('{addr: 32'(i * 4), data: w});
      nwr++;
      if (w == HALT) begin
        halted = 1'b1;
        break;
      end
    end
`ifdef LOADER_CHECKSUM_EN
    exp_done = halted && csum_ok;
`else
    exp_done = halted;
`endif
    start_session();
    for (int i = 0; i < nsend; i++) begin
      w = words[i];
      for (int b = 0; b < 4; b++) send_byte(w[31 - 8 * b -: 8], gap);
    end
`ifdef LOADER_CHECKSUM_EN
    if (halted) send_byte(csum_ok ? sum : sum + 8'd1, gap);
`endif
    n = 0;
    while (!(bus.o_done === 1'b1 || bus.o_error === 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("done", {63'd0, bus.o_done}, {63'd0, exp_done});
    chk("error", {63'd0, bus.o_error}, {63'd0, !exp_done});
    chk("cpu_rst_n", {63'd0, bus.o_cpu_rst_n}, {63'd0, exp_done});
    chk("halt", {63'd0, bus.o_halt}, {63'd0, !exp_done});
    chk("word_count", 64'(bus.o_word_count), 64'(nwr));
    chk("writes_outstanding", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin : stim
    logic [31:0] prog[$];
    logic [31:0] w;
    int          len;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.i_start = 1'b0;
    bus.i_byte_valid = 1'b0;
    bus.i_byte = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_rst_n", {63'd0, bus.o_cpu_rst_n}, 64'd0);
    chk("rst_halt", {63'd0, bus.o_halt}, 64'd1);
    chk("rst_we", {63'd0, bus.o_we_IF}, 64'd0);
    chk("rst_addr", {32'd0, bus.o_inst_addr}, 64'd0);
    chk("rst_count", 64'(bus.o_word_count), 64'd0);
    chk("rst_ready", {63'd0, bus.o_byte_ready}, 64'd0);
    chk("rst_done_error", {62'd0, bus.o_done, bus.o_error}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    prog = '{32'h2001_000F, HALT};
    run_session(prog, 0, 1'b1);

    prog = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h5555_5555};
    run_session(prog, 0, 1'b1);

    prog = '{32'h2001_000F, HALT};
    run_session(prog, 0, 1'b1);
    run_session(prog, 3, 1'b1);

    // Abort a word halfway through with a reset pulse.
    start_session();
    send_byte(8'h20, 0);
    send_byte(8'h01, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_cpu_rst_n", {63'd0, bus.o_cpu_rst_n}, 64'd0);
    chk("abort_addr", {32'd0, bus.o_inst_addr}, 64'd0);
    chk("abort_ready", {63'd0, bus.o_byte_ready}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    prog = '{32'hDEAD_BEEF, 32'h0000_0013, HALT};
    run_session(prog, 1, 1'b1);

`ifdef LOADER_CHECKSUM_EN
    prog = '{32'h0000_0001, HALT};
    run_session(prog, 0, 1'b1);
    run_session(prog, 0, 1'b0);
`endif

    for (int s = 0; s < 25; s++) begin
      prog.delete();
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        w = $urandom;
        if (w == HALT) w = 32'd0;
        prog.push_back(w);
      end
      if (len <= MAXW || $urandom_range(0, 1) == 1) prog[len - 1] = HALT;
      run_session(prog, $urandom_range(0, 2), $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_loader.md
# inst_loader

Parametrised program loader between a byte-wide host link (UART RX) and the pipeline's instruction-memory write port and control inputs. It assembles incoming bytes into instruction words and writes them to consecutive addresses with one-cycle write pulses, stopping when it sees the HALT word. It then holds the pipeline in reset for a programmable number of cycles and releases it into execution. It replaces the manual load, second reset and release sequencing the pipeline has needed so far.

## Interface
Parameters:
- NB_DATA, 32, instruction word width; must be a multiple of NB_BYTE
- NB_BYTE, 8, link byte width
- NB_ADDR, 32, instruction address width
- START_ADDR, 0, address of the first written word
- ADDR_STEP, 4, address increment per word
- MAX_WORDS, 64, capacity in words, HALT word included
- HALT_WORD, 32'hFFFFFFFF, terminator word
- RST_CYCLES, 2, length of the pipeline reset pulse in cycles (≥1)

Ports:
- clk  in  1  system clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start a new load session
- i_byte_valid  in  1  link byte valid
- i_byte  in  NB_BYTE  link byte
- o_byte_ready  out  1  loader accepts a byte this cycle
- o_we_IF  out  1  instruction-memory write enable
- o_inst_addr  out  NB_ADDR  instruction-memory write address
- o_instruction_data  out  NB_DATA  instruction-memory write data
- o_cpu_rst_n  out  1  pipeline reset, active low
- o_halt  out  1  pipeline halt
- o_done  out  1  program loaded and pipeline running
- o_error  out  1  session failed (overflow or checksum)
- o_word_count  out  $clog2(MAX_WORDS+1)  number of words written this session

## Operation
- States: IDLE, LOAD, WRITE, CHECK (LOADER_CHECKSUM_EN builds only), RSTP, RUN, ERROR.
- Reset values: state IDLE; o_byte_ready 0; o_we_IF 0; o_inst_addr START_ADDR; o_instruction_data 0; o_cpu_rst_n 0; o_halt 1; o_done 0; o_error 0; o_word_count 0; byte index 0.
- i_start in IDLE, RUN or ERROR moves to LOAD. On entry to LOAD:
  - o_inst_addr becomes START_ADDR; o_word_count and byte index become 0.
  - o_cpu_rst_n goes to 0, o_halt to 1, o_done and o_error to 0.
  - i_start is ignored in LOAD, WRITE, CHECK and RSTP.
- LOAD:
  - o_byte_ready is 1. A byte is accepted on i_byte_valid & o_byte_ready.
  - Bytes are packed MSB first: the first byte of a word lands in bits [NB_DATA-1 -: NB_BYTE].
  - On the (NB_DATA/NB_BYTE)th byte, the word is complete. If o_word_count == MAX_WORDS, go to ERROR and write nothing. Otherwise go to WRITE.
- WRITE:
  - Lasts exactly one cycle. o_we_IF = 1, o_byte_ready = 0, and o_inst_addr / o_instruction_data hold the word.
  - On leaving WRITE, o_inst_addr += ADDR_STEP (wraps modulo 2^NB_ADDR) and o_word_count += 1.
  - If the word equals HALT_WORD, go to CHECK (checksum builds) or RSTP. Otherwise return to LOAD.
  - The HALT word itself is written to memory.
- RSTP: o_cpu_rst_n = 0 and o_halt = 1 for RST_CYCLES cycles, then RUN.
- RUN: o_cpu_rst_n = 1, o_halt = 0, o_done = 1, o_byte_ready = 0. Stays there until i_start or reset.
- ERROR: o_error = 1, o_cpu_rst_n = 0, o_halt = 1, o_byte_ready = 0. Only i_start or reset leaves it.
- i_rst_n asserted mid-session aborts it at once. All outputs return to their reset values; o_cpu_rst_n = 0 keeps the pipeline held.

## Timing
- Byte accepted at edge N with a complete word: o_we_IF is high during cycle N+1 only. o_byte_ready is 1 again from N+2.
- Back-to-back bytes: a 4-byte word takes 5 cycles minimum (4 accept cycles plus 1 write cycle).
- HALT written at cycle W: RSTP spans cycles W+1 .. W+RST_CYCLES. o_cpu_rst_n and o_halt release and o_done rises at W+RST_CYCLES+1 (without checksum).
- All outputs are registered. No combinational path from any input to any output.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After the HALT write the FSM enters CHECK with o_byte_ready = 1 and accepts one byte.
  - That byte must equal the modulo-2^NB_BYTE sum of all data bytes received this session, HALT bytes included.
  - Match goes to RSTP; mismatch goes to ERROR. The running sum is cleared on LOAD entry.
- LOADER_CHECKSUM_EN undefined: no CHECK state and no sum register. WRITE of HALT goes directly to RSTP.

## Test plan
- Reset: i_rst_n low → o_cpu_rst_n 0, o_halt 1, o_we_IF 0, o_inst_addr 0, o_word_count 0.
- Load 20 01 00 0F, then FF FF FF FF → two writes: 0x2001000F @0x0, then 0xFFFFFFFF @0x4. o_word_count 2. o_cpu_rst_n low 2 cycles, then o_done 1 and o_halt 0.
- MAX_WORDS=4, send 5 non-HALT words → 4 writes at 0x0–0xC, then o_error 1 with no fifth o_we_IF. i_start afterwards restarts at 0x0.
- Gapped byte stream (valid low 3 cycles between bytes) → identical writes, with o_we_IF exactly one cycle per word.
- i_rst_n pulsed after the second byte of word 1, then i_start and a full program → no write from the aborted word; the first write lands at START_ADDR.
- LOADER_CHECKSUM_EN: program {0x00000001, HALT}, checksum byte 0xFD → RUN. Checksum byte 0xFE → o_error 1 with o_cpu_rst_n still 0.
